// File: rtl/dma_controller_pkg.sv
// rtl/dma_controller_pkg.sv - shared DMA state encodings, transfer constants and count helper
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE = 16;
  localparam int DMA_XFER_LEN  = 12;
  localparam int DMA_BURST_LEN = 4;
  localparam int DMA_DONE_CODE = 11;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_REQ,
    DMA_FETCH,
    DMA_WRITE,
    DMA_RELEASE,
    DMA_DONE
  } dma_state_e;

  // Progress shown while busy never reaches DONE_CODE, so the stall logic keeps stalling.
  function automatic logic [3:0] dma_sat_count(input logic [3:0] words);
    return (words > 4'(DMA_DONE_CODE - 1)) ? 4'(DMA_DONE_CODE - 1) : words;
  endfunction

  function automatic logic dma_burst_end(input logic [3:0] words);
    return ({28'd0, words} % DMA_BURST_LEN) == 0;
  endfunction

endpackage

// File: rtl/dma_controller_addr_gen.sv
// rtl/dma_controller_addr_gen.sv - base/index address generator and dma_counter progress register
module dma_controller_addr_gen
  import dma_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        advance,
  input  logic        finish,
  output logic [15:0] addr,
  output logic [3:0]  idx,
  output logic [3:0]  counter
);

  logic [15:0] base_q, base_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_inc;

  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (load) begin
      base_d = load_addr;
      idx_d  = 4'd0;
      cnt_d  = 4'd0;
    end else if (advance) begin
      idx_d = idx_inc;
      cnt_d = finish ? 4'(DMA_DONE_CODE) : dma_sat_count(idx_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= 16'd0;
      idx_q  <= 4'd0;
      cnt_q  <= 4'd0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  // Wraps modulo 2^16 by construction.
  assign addr    = base_q + {12'd0, idx_q};
  assign idx     = idx_q;
  assign counter = cnt_q;

endmodule

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - single-command device-to-memory DMA engine with BR/BG arbitration
// Optional: DMA_BURST_RELEASE_EN drops BR for one cycle between bursts.
module dma_controller
  import dma_controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_addr,
  output logic        cmd_ready,
  output logic        BR,
  input  logic        BG,
  input  logic        dev_valid,
  input  logic [15:0] dev_data,
  output logic        dev_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic [3:0]  dma_counter,
  output logic        dma_done
);

  dma_state_e  state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        load, advance, finish;
  logic [3:0]  idx;

  dma_controller_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (reset_n),
    .load      (load),
    .load_addr (cmd_addr),
    .advance   (advance),
    .finish    (finish),
    .addr      (mem_addr),
    .idx       (idx),
    .counter   (dma_counter)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    BR        = 1'b0;
    dev_ready = 1'b0;
    mem_write = 1'b0;
    dma_done  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state_q)
      DMA_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load    = 1'b1;
          state_d = DMA_REQ;
        end
      end
      DMA_REQ: begin
        BR = 1'b1;
        if (BG) state_d = DMA_FETCH;
      end
      DMA_FETCH: begin
        BR = 1'b1;
        if (BG && dev_valid) begin
          dev_ready = 1'b1;
          state_d   = DMA_WRITE;
        end
      end
      DMA_WRITE: begin
        // Strobe stays up through a lost grant; the ack only counts while granted.
        BR        = 1'b1;
        mem_write = 1'b1;
        if (BG && mem_ack) begin
          advance = 1'b1;
          if (idx == 4'(DMA_XFER_LEN - 1)) begin
            finish  = 1'b1;
            state_d = DMA_DONE;
          end else begin
`ifdef DMA_BURST_RELEASE_EN
            state_d = dma_burst_end(idx + 4'd1) ? DMA_RELEASE : DMA_FETCH;
`else
            state_d = DMA_FETCH;
`endif
          end
        end
      end
      DMA_RELEASE: state_d = DMA_REQ;
      DMA_DONE: begin
        dma_done = 1'b1;
        state_d  = DMA_IDLE;
      end
      default: state_d = DMA_IDLE;
    endcase
    data_d = dev_ready ? dev_data : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DMA_IDLE;
      data_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign mem_wdata = data_q;

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - directed table-driven bench for dma_controller
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic        cmd_ready;
  logic        BR;
  logic        BG = 1'b0;
  logic        dev_valid = 1'b1;
  logic [15:0] dev_data = 16'd0;
  logic        dev_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_ack = 1'b1;
  logic [3:0]  dma_counter;
  logic        dma_done;

  int errors = 0;
  int checks = 0;
  int gaps;
  int gap_pos[4];

  dma_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_ready   (cmd_ready),
    .BR          (BR),
    .BG          (BG),
    .dev_valid   (dev_valid),
    .dev_data    (dev_data),
    .dev_ready   (dev_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_ack     (mem_ack),
    .dma_counter (dma_counter),
    .dma_done    (dma_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          gdelay;
    int          busy_at;
    logic [15:0] last_addr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int v, input int i);
    return 16'hD000 | 16'(v << 8) | 16'(i);
  endfunction

  task automatic run_xfer(input int vi, input logic [15:0] addr, input int gdelay,
                          input int busy_at, input int abort_at,
                          output int writes, output logic [15:0] last_wr, output int dones);
    int wr_i = 0;
    int sent = 0;
    int br_cnt = 0;
    logic prev_br = 1'b1;
    logic done_seen = 1'b0;
    logic [15:0] exp_addr;
    dones = 0;
    last_wr = 16'd0;
    gaps = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    BG        = 1'b0;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = (busy_at > 0 && cyc == busy_at);
      cmd_addr  = (busy_at > 0 && cyc == busy_at) ? 16'h0400 : addr;
      BG        = (br_cnt >= gdelay);
      dev_data  = pat(vi, sent);
      @(negedge clk);
      if (cyc == 0) chk("br_latency", BR, 1);
      if (BR) br_cnt++;
      if (!BG) begin
        chk("nogrant_br", BR, 1);
        chk("nogrant_dev_ready", dev_ready, 0);
        chk("nogrant_mem_write", mem_write, 0);
      end
      chk("cmd_ready_busy", cmd_ready, 0);
      if (dma_done) begin
        dones++;
        done_seen = 1'b1;
        chk("done_br_low", BR, 0);
        chk("done_counter", dma_counter, 11);
      end else begin
        chk("counter_progress", dma_counter, (wr_i > 10) ? 10 : wr_i);
        if (!BR) begin
          if (gaps < 4) gap_pos[gaps] = wr_i;
          gaps++;
          chk("gap_one_cycle", prev_br, 1);
        end
      end
      if (dev_ready) sent++;
      if (mem_write) begin
        exp_addr = addr + 16'(wr_i);
        chk("write_addr", mem_addr, exp_addr);
        chk("write_data", mem_wdata, pat(vi, wr_i));
        last_wr = mem_addr;
        wr_i++;
      end
      prev_br = BR;
      if (done_seen || (abort_at > 0 && wr_i == abort_at)) break;
    end
    writes = wr_i;
    if (abort_at == 0) begin
      chk("finished", done_seen, 1);
      @(posedge clk); #1;
      BG = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("post_counter_hold", dma_counter, 11);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_br_low", BR, 0);
        chk("post_no_done", dma_done, 0);
      end
    end
  endtask

  initial begin
    vec_t vecs[4];
    int writes, dones;
    logic [15:0] last_wr;

    vecs[0] = '{addr: 16'h01F0, gdelay: 1, busy_at: 0, last_addr: 16'h01FB};
    vecs[1] = '{addr: 16'h2000, gdelay: 5, busy_at: 0, last_addr: 16'h200B};
    vecs[2] = '{addr: 16'hFFFE, gdelay: 1, busy_at: 0, last_addr: 16'h0009};
    vecs[3] = '{addr: 16'h1234, gdelay: 2, busy_at: 6, last_addr: 16'h123F};

    #12;
    chk("rst_br", BR, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_dev_ready", dev_ready, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_counter", dma_counter, 0);
    chk("rst_done", dma_done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_br", BR, 0);
      chk("idle_counter", dma_counter, 0);
    end

    for (int v = 0; v < 4; v++) begin
      run_xfer(v, vecs[v].addr, vecs[v].gdelay, vecs[v].busy_at, 0, writes, last_wr, dones);
      chk("write_count", writes, 12);
      chk("last_addr", last_wr, vecs[v].last_addr);
      chk("done_pulses", dones, 1);
`ifdef DMA_BURST_RELEASE_EN
      chk("release_gaps", gaps, 2);
      chk("release_at_4", gap_pos[0], 4);
      chk("release_at_8", gap_pos[1], 8);
`else
      chk("no_release_gaps", gaps, 0);
`endif
    end

    run_xfer(9, 16'h3000, 1, 0, 6, writes, last_wr, dones);
    chk("abort_writes", writes, 6);
    @(posedge clk); #1;
    reset_n = 1'b0;
    BG      = 1'b0;
    #1;
    chk("abort_br_low", BR, 0);
    chk("abort_mem_write", mem_write, 0);
    chk("abort_counter", dma_counter, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dma_done) dones++;
      if (BR) dones += 100;
    end
    chk("abort_no_done_no_br", dones, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
